ahb_master_arbiter: RTL

Two-master AHB-Lite arbiter that shares the single system AHB-Lite bus between the Cortex-M0 (master 0) and a second bus master such as a DMA engine (master 1). It sits between the masters and the address decoder / slave multiplexer. It muxes address, control and write data from the owning master onto the shared bus, and stalls the non-owning master through its private HREADY. Ownership changes only at transfer boundaries where no data phase is lost, so neither master nor any slave needs to know the arbiter exists.

---
 rtl/ahb_master_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: muxes M0/M1 address, control and write data onto one shared bus.
// Latency: a non-owner request seen with the owner IDLE/unlocked and HREADY=1 reaches HADDR one cycle later.
// Backpressure: the owner sees the shared HREADY; a requesting non-owner is stalled through its private HREADY.
// Optional grant statistics counters are enabled by defining ARB_STATS_EN.
module ahb_master_arbiter #(
   parameter bit DEFAULT_MASTER = 1'b0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] HADDR_M0,
   input  logic [1:0]  HTRANS_M0,
   input  logic        HWRITE_M0,
   input  logic [2:0]  HSIZE_M0,
   input  logic [3:0]  HPROT_M0,
   input  logic        HMASTLOCK_M0,
   input  logic [31:0] HWDATA_M0,
   input  logic [31:0] HADDR_M1,
   input  logic [1:0]  HTRANS_M1,
   input  logic        HWRITE_M1,
   input  logic [2:0]  HSIZE_M1,
   input  logic [3:0]  HPROT_M1,
   input  logic        HMASTLOCK_M1,
   input  logic [31:0] HWDATA_M1,
   output logic        HREADY_M0,
   output logic        HREADY_M1,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HMASTER,
   output logic        HMASTER_D
`ifdef ARB_STATS_EN
   ,
   output logic [15:0] GRANT_CNT_M0,
   output logic [15:0] GRANT_CNT_M1
`endif
);

   typedef enum logic {
      OWN0 = 1'b0,
      OWN1 = 1'b1
   } owner_t;

   owner_t owner;
   owner_t owner_nxt;
   logic   hmaster_d_r;

   // Ownership register: resets to the configured default master.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         owner <= owner_t'(DEFAULT_MASTER);
      end else begin
         owner <= owner_nxt;
      end
   end

   // Hand the bus over only after an accepted, unlocked IDLE address phase of the owner.
   always_comb begin
      owner_nxt = owner;
      case (owner)
         OWN0: begin
            if (HREADY && (HTRANS_M0 == 2'b00) && !HMASTLOCK_M0 && HTRANS_M1[1]) begin
               owner_nxt = OWN1;
            end
         end
         OWN1: begin
            if (HREADY && (HTRANS_M1 == 2'b00) && !HMASTLOCK_M1 && HTRANS_M0[1]) begin
               owner_nxt = OWN0;
            end
         end
         default: owner_nxt = owner;
      endcase
   end

   // Data-phase owner follows the address-phase owner on every accepted edge.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         hmaster_d_r <= DEFAULT_MASTER;
      end else if (HREADY) begin
         hmaster_d_r <= owner;
      end
   end

   // Shared-bus muxes and per-master ready; a non-owner is stalled only while it requests.
   always_comb begin
      HMASTER   = owner;
      HMASTER_D = hmaster_d_r;
      if (owner == OWN1) begin
         HADDR     = HADDR_M1;
         HTRANS    = HTRANS_M1;
         HWRITE    = HWRITE_M1;
         HSIZE     = HSIZE_M1;
         HPROT     = HPROT_M1;
         HMASTLOCK = HMASTLOCK_M1;
         HREADY_M1 = HREADY;
         HREADY_M0 = ~HTRANS_M0[1];
      end else begin
         HADDR     = HADDR_M0;
         HTRANS    = HTRANS_M0;
         HWRITE    = HWRITE_M0;
         HSIZE     = HSIZE_M0;
         HPROT     = HPROT_M0;
         HMASTLOCK = HMASTLOCK_M0;
         HREADY_M0 = HREADY;
         HREADY_M1 = ~HTRANS_M1[1];
      end
      HWDATA = hmaster_d_r ? HWDATA_M1 : HWDATA_M0;
   end

`ifdef ARB_STATS_EN
   logic [15:0] grant_cnt_m0_r;
   logic [15:0] grant_cnt_m1_r;

   // Count accepted address phases per owner, saturating at all-ones.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         grant_cnt_m0_r <= 16'h0000;
         grant_cnt_m1_r <= 16'h0000;
      end else if (HREADY && HTRANS[1]) begin
         if ((owner == OWN0) && (grant_cnt_m0_r != 16'hFFFF)) begin
            grant_cnt_m0_r <= grant_cnt_m0_r + 16'd1;
         end
         if ((owner == OWN1) && (grant_cnt_m1_r != 16'hFFFF)) begin
            grant_cnt_m1_r <= grant_cnt_m1_r + 16'd1;
         end
      end
   end

   assign GRANT_CNT_M0 = grant_cnt_m0_r;
   assign GRANT_CNT_M1 = grant_cnt_m1_r;
`endif

endmodule
